writeback_arbiter: RTL and testbench
====================================

# writeback_arbiter

Write-side front end for the 32x32 integer/float register file. It collects writeback requests from two producers into a small in-order queue and drives the register file's single write port. Source A is the single-cycle integer/load path; source B is the multi-cycle FPU path. It issues at most one write per cycle, discards illegal writes, and reports queued-but-unwritten destinations to hazard logic.

## Interface
- DEPTH, 4, queue entries (power of two, ≥2)
- STARVE_LIMIT, 3, consecutive cycles B may be refused before it gets priority
- clk  input  1  clock; all state updates on posedge
- rst_n  input  1  synchronous active-low reset
- validA / validB  input  1  request present on source A / B
- readyA / readyB  output  1  request accepted this cycle (handshake = valid & ready at posedge)
- regA / regB  input  6  destination register index
- dataA / dataB  input  32  write data
- floatA / floatB  input  1  1 = float bank, 0 = integer bank
- writeReg  output  6  to register file
- writeData  output  32  to register file
- regWrite  output  1  to register file; write strobe
- float  output  1  to register file; bank select
- lookupReg  input  6  hazard query index
- lookupFloat  input  1  hazard query bank
- pendingHit  output  1  query matches a queued entry
- errFlag  output  1  sticky; an out-of-range index was discarded

## Operation
- Storage: circular queue of DEPTH entries {reg, data, float}, with rdPtr, wrPtr, and count (0..DEPTH).
- Output stage is the queue head:
  - regWrite = (count != 0).
  - writeReg, writeData, and float come from the head entry; all are 0 when count == 0.
  - No combinational path from any A/B input to these four outputs.
- Pop: every cycle with count != 0, the head is retired at posedge. The register file always accepts.
- Free slots: free = DEPTH − count. The current cycle's pop is not credited.
- starve = (starveCnt ≥ STARVE_LIMIT).
- Arbitration (combinational readies):
  - free ≥ 2: readyA = validA, readyB = validB. Both may be accepted in the same cycle.
  - free == 1, only one source valid: that source is ready.
  - free == 1, both valid: readyA = !starve, readyB = starve.
  - free == 0: readyA = readyB = 0.
- Enqueue order: A is enqueued before B when both are accepted in the same cycle. Queue order is retirement order.
- Discard rules (request is still handshaken, i.e. ready asserted and counted against free, but no entry is written):
  - Integer bank, reg == 0.
  - reg ≥ 32 (bit 5 set), either bank. Also sets errFlag, which stays set until reset.
  - Float reg 0 is a legal destination.
- starveCnt (saturating, width ≥ log2(STARVE_LIMIT)+1):
  - Increments when validB & !readyB.
  - Clears when B is accepted or validB == 0.
- pendingHit = 1 if any occupied entry has reg == lookupReg and float == lookupFloat. This is combinational over stored state and lookup inputs only.
- Count update: count_next = count − pop + enqA + enqB. Simultaneous push and pop is legal at any fill level.

## Timing
- Reset (rst_n == 0 at posedge):
  - Internal state: count = 0, pointers = 0, starveCnt = 0, errFlag = 0.
  - While rst_n is low: readyA = readyB = 0, regWrite = 0, writeReg/writeData/float = 0, pendingHit = 0.
  - Reset mid-operation drops all queued writes; nothing is written afterwards.
- Latency: a request accepted at posedge N into an empty queue drives regWrite = 1 during cycle N+1 and is written by the register file at posedge N+1.
- Throughput: one write per cycle sustained. Input acceptance peaks at two per cycle until the queue fills.
- Full queue: with count == DEPTH, no accept is possible that cycle. The next cycle has free ≥ 1 because of the pop.
- Wrap: pointers wrap modulo DEPTH with no bubble.
- Hazard visibility:
  - pendingHit rises the cycle after acceptance.
  - It falls the cycle after the matching entry retires, unless another matching entry remains queued.
- Discarded requests never produce regWrite and never set pendingHit.

## Test plan
- Single write: reset, then A {reg 5, int, 0xDEADBEEF} for one cycle → readyA = 1; next cycle regWrite = 1, writeReg = 5, float = 0, writeData = 0xDEADBEEF; the following cycle regWrite = 0.
- Dual accept and order: A {int r3, 0x11} and B {float r3, 0x22} in the same cycle on an empty queue → two consecutive write cycles, r3 int 0x11 then r3 float 0x22.
- Starvation: DEPTH 4; hold the queue with free == 1 using A every cycle while B is continuously valid → B is refused 3 cycles, then readyB = 1 and readyA = 0 on the 4th cycle; starveCnt clears.
- Discards: A int r0 → handshake with no regWrite. B float r0 → written. A reg 40 → handshake, no write, errFlag = 1 until reset.
- Hazard: enqueue float r7 with the queue holding 3 older entries; lookup float r7 → pendingHit = 1 from the next cycle until the cycle after r7 retires; lookup int r7 → 0 throughout.
- Reset mid-stream: queue full, drive rst_n = 0 for one posedge → regWrite = 0 from that point; no queued writes appear afterwards; readyA = 1 again once rst_n is high.

Source files
------------

// File: rtl/writeback_arbiter_if.sv
// Bundle of the writeback arbiter's producer, register-file and hazard-query signals.
// The slave view belongs to the arbiter; the master view belongs to whatever drives it.
interface writeback_arbiter_if;
  logic        valid_a;
  logic        ready_a;
  logic [5:0]  reg_a;
  logic [31:0] data_a;
  logic        float_a;

  logic        valid_b;
  logic        ready_b;
  logic [5:0]  reg_b;
  logic [31:0] data_b;
  logic        float_b;

  logic [5:0]  write_reg;
  logic [31:0] write_data;
  logic        reg_write;
  logic        write_float;

  logic [5:0]  lookup_reg;
  logic        lookup_float;
  logic        pending_hit;
  logic        err_flag;

  modport master (
    output valid_a, reg_a, data_a, float_a,
    output valid_b, reg_b, data_b, float_b,
    output lookup_reg, lookup_float,
    input  ready_a, ready_b,
    input  write_reg, write_data, reg_write, write_float,
    input  pending_hit, err_flag
  );

  modport slave (
    input  valid_a, reg_a, data_a, float_a,
    input  valid_b, reg_b, data_b, float_b,
    input  lookup_reg, lookup_float,
    output ready_a, ready_b,
    output write_reg, write_data, reg_write, write_float,
    output pending_hit, err_flag
  );
endinterface

// File: rtl/writeback_arbiter.sv
// Two-source writeback queue feeding the register file's single write port.
// Source B (FPU) gets priority after STARVE_LIMIT refusals while the queue is nearly full.
module writeback_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3
) (
  input logic               clk,
  input logic               rst_n,
  writeback_arbiter_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [5:0]  rg;
    logic [31:0] data;
    logic        flt;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;
  logic [SW-1:0]   starve_cnt;
  logic            err_q;

  logic [CW-1:0]   free;
  logic            starve, pop;
  logic            acc_a, acc_b, keep_a, keep_b;
  logic [PW-1:0]   wr_ptr_b;
  entry_t          head;

  assign free   = CW'(DEPTH) - count;
  assign starve = (starve_cnt >= SW'(STARVE_LIMIT));
  assign pop    = (count != '0);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    bus.ready_a = 1'b0;
    bus.ready_b = 1'b0;
    if (rst_n) begin
      if (free >= CW'(2)) begin
        bus.ready_a = bus.valid_a;
        bus.ready_b = bus.valid_b;
      end else if (free == CW'(1)) begin
        if (bus.valid_a && bus.valid_b) begin
          bus.ready_a = !starve;
          bus.ready_b = starve;
        end else begin
          bus.ready_a = bus.valid_a;
          bus.ready_b = bus.valid_b;
        end
      end
    end
  end

  // Integer r0 and any index with bit 5 set are handshaken but never stored.
  assign acc_a    = bus.valid_a && bus.ready_a;
  assign acc_b    = bus.valid_b && bus.ready_b;
  assign keep_a   = acc_a && !bus.reg_a[5] && (bus.float_a || bus.reg_a != 6'd0);
  assign keep_b   = acc_b && !bus.reg_b[5] && (bus.float_b || bus.reg_b != 6'd0);
  assign wr_ptr_b = wr_ptr + PW'(keep_a);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      err_q      <= 1'b0;
    end else begin
      rd_ptr <= rd_ptr + PW'(pop);
      wr_ptr <= wr_ptr + PW'(keep_a) + PW'(keep_b);
      count  <= count - CW'(pop) + CW'(keep_a) + CW'(keep_b);
      if (bus.valid_b && !bus.ready_b) begin
        if (!starve) starve_cnt <= starve_cnt + SW'(1);
      end else begin
        starve_cnt <= '0;
      end
      err_q <= err_q | (acc_a && bus.reg_a[5]) | (acc_b && bus.reg_b[5]);
    end
  end

  // NOTE: queue storage is deliberately not reset; count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (keep_a) mem[wr_ptr]   <= '{rg: bus.reg_a, data: bus.data_a, flt: bus.float_a};
    if (keep_b) mem[wr_ptr_b] <= '{rg: bus.reg_b, data: bus.data_b, flt: bus.float_b};
  end

  assign head            = mem[rd_ptr];
  assign bus.reg_write   = rst_n && pop;
  assign bus.write_reg   = bus.reg_write ? head.rg   : 6'd0;
  assign bus.write_data  = bus.reg_write ? head.data : 32'd0;
  assign bus.write_float = bus.reg_write ? head.flt  : 1'b0;
  assign bus.err_flag    = err_q;

  // Slot i is live when its distance from the head is below count.
  always_comb begin
    logic [PW-1:0] offs;
    offs            = '0;
    bus.pending_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      offs = PW'(i) - rd_ptr;
      if (rst_n && (CW'(offs) < count) &&
          mem[i].rg == bus.lookup_reg && mem[i].flt == bus.lookup_float)
        bus.pending_hit = 1'b1;
    end
  end
endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: stimulus pushes expected writes to a scoreboard,
// a negedge monitor retires them against the register-file port.
module tb_writeback_arbiter;
  typedef struct packed {
    logic        v;
    logic [5:0]  rg;
    logic [31:0] data;
    logic        flt;
  } req_t;

  typedef struct packed {
    logic [5:0]  rg;
    logic [31:0] data;
    logic        flt;
  } wr_t;

  localparam req_t NONE = '0;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;
  wr_t  sb[$];

  writeback_arbiter_if bus();

  writeback_arbiter #(.DEPTH(4), .STARVE_LIMIT(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic req_t rq(input logic [5:0] r, input logic [31:0] d, input logic f);
    return '{v: 1'b1, rg: r, data: d, flt: f};
  endfunction

  function automatic logic legal(input req_t r);
    return r.v && !r.rg[5] && (r.flt || r.rg != 6'd0);
  endfunction

  // One cycle: drive both sources, check readies, queue whatever should reach the register file.
  task automatic step(input req_t a, input req_t b, input logic exp_ra, input logic exp_rb);
    @(posedge clk);
    #1;
    bus.valid_a = a.v; bus.reg_a = a.rg; bus.data_a = a.data; bus.float_a = a.flt;
    bus.valid_b = b.v; bus.reg_b = b.rg; bus.data_b = b.data; bus.float_b = b.flt;
    #1;
    check("ready_a", bus.ready_a, exp_ra);
    check("ready_b", bus.ready_b, exp_rb);
    if (exp_ra && legal(a)) sb.push_back('{rg: a.rg, data: a.data, flt: a.flt});
    if (exp_rb && legal(b)) sb.push_back('{rg: b.rg, data: b.data, flt: b.flt});
  endtask

  task automatic idle(input int n);
    repeat (n) step(NONE, NONE, 1'b0, 1'b0);
  endtask

  // Float lookup of the current lookup_reg must equal exp; the integer twin must stay clear.
  task automatic hit_chk(input string name, input logic exp);
    bus.lookup_float = 1'b1;
    #1;
    check({name, "_float"}, bus.pending_hit, exp);
    bus.lookup_float = 1'b0;
    #1;
    check({name, "_int"}, bus.pending_hit, 1'b0);
  endtask

  initial begin : monitor
    wr_t e;
    forever begin
      @(negedge clk);
      if (bus.reg_write === 1'b1) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_write: got reg %0d data %0h float %0b expected no write",
                   bus.write_reg, bus.write_data, bus.write_float);
        end else begin
          e = sb.pop_front();
          check("wr_reg", bus.write_reg, e.rg);
          check("wr_data", bus.write_data, e.data);
          check("wr_float", bus.write_float, e.flt);
        end
      end else begin
        check("idle_outputs_zero", {bus.write_reg, bus.write_data, bus.write_float}, '0);
      end
    end
  end

  initial begin : stimulus
    rst_n = 1'b0;
    {bus.valid_a, bus.reg_a, bus.data_a, bus.float_a} = '0;
    {bus.valid_b, bus.reg_b, bus.data_b, bus.float_b} = '0;
    bus.lookup_reg   = 6'd5;
    bus.lookup_float = 1'b0;

    // Reset: a valid request is never accepted while rst_n is low
    @(posedge clk); #1;
    bus.valid_a = 1'b1; bus.reg_a = 6'd5; bus.data_a = 32'h1;
    #1;
    check("rst_ready_a", bus.ready_a, 1'b0);
    check("rst_reg_write", bus.reg_write, 1'b0);
    check("rst_pending_hit", bus.pending_hit, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.valid_a = 1'b0;
    #1;
    check("rst_err_flag", bus.err_flag, 1'b0);
    check("rst_idle_write", bus.reg_write, 1'b0);

    // Single write and its one-cycle latency
    step(rq(6'd5, 32'hDEADBEEF, 1'b0), NONE, 1'b1, 1'b0);
    step(NONE, NONE, 1'b0, 1'b0);
    check("single_latency", bus.reg_write, 1'b1);
    check("single_reg", bus.write_reg, 6'd5);
    step(NONE, NONE, 1'b0, 1'b0);
    check("single_done", bus.reg_write, 1'b0);

    // Dual accept: A retires before B
    step(rq(6'd3, 32'h11, 1'b0), rq(6'd3, 32'h22, 1'b1), 1'b1, 1'b1);
    step(NONE, NONE, 1'b0, 1'b0);
    check("dual_first_float", bus.write_float, 1'b0);
    step(NONE, NONE, 1'b0, 1'b0);
    check("dual_second_float", bus.write_float, 1'b1);
    idle(2);

    // Starvation: free == 1 held by A, B refused three times, then wins once
    step(rq(6'd1, 32'hA1, 1'b0), rq(6'd2, 32'hB1, 1'b0), 1'b1, 1'b1);
    step(rq(6'd3, 32'hA2, 1'b0), rq(6'd4, 32'hB2, 1'b0), 1'b1, 1'b1);
    step(rq(6'd5, 32'hA3, 1'b0), rq(6'd6, 32'hB3, 1'b0), 1'b1, 1'b0);
    step(rq(6'd5, 32'hA4, 1'b0), rq(6'd6, 32'hB3, 1'b0), 1'b1, 1'b0);
    step(rq(6'd5, 32'hA5, 1'b0), rq(6'd6, 32'hB3, 1'b0), 1'b1, 1'b0);
    step(rq(6'd5, 32'hA6, 1'b0), rq(6'd6, 32'hB3, 1'b0), 1'b0, 1'b1);
    step(rq(6'd5, 32'hA6, 1'b0), rq(6'd6, 32'hB4, 1'b0), 1'b1, 1'b0);
    idle(5);

    // Discards: int r0 dropped, float r0 written, r40 dropped and sets the sticky error
    check("err_before_discard", bus.err_flag, 1'b0);
    step(rq(6'd0, 32'hD0, 1'b0), NONE, 1'b1, 1'b0);
    step(NONE, rq(6'd0, 32'hF0, 1'b1), 1'b0, 1'b1);
    step(rq(6'd40, 32'hE0, 1'b0), NONE, 1'b1, 1'b0);
    step(NONE, NONE, 1'b0, 1'b0);
    check("err_after_r40", bus.err_flag, 1'b1);
    idle(4);
    check("err_sticky", bus.err_flag, 1'b1);

    // Hazard: float r7 behind three older entries
    bus.lookup_reg = 6'd7;
    step(rq(6'd1, 32'h71, 1'b0), rq(6'd2, 32'h72, 1'b0), 1'b1, 1'b1);
    hit_chk("hz_c0", 1'b0);
    step(rq(6'd3, 32'h73, 1'b0), rq(6'd4, 32'h74, 1'b0), 1'b1, 1'b1);
    hit_chk("hz_c1", 1'b0);
    step(rq(6'd7, 32'h77, 1'b1), NONE, 1'b1, 1'b0);
    hit_chk("hz_c2", 1'b0);
    step(NONE, NONE, 1'b0, 1'b0);
    hit_chk("hz_c3", 1'b1);
    step(NONE, NONE, 1'b0, 1'b0);
    hit_chk("hz_c4", 1'b1);
    step(NONE, NONE, 1'b0, 1'b0);
    hit_chk("hz_c5", 1'b1);
    step(NONE, NONE, 1'b0, 1'b0);
    hit_chk("hz_c6", 1'b0);
    idle(2);

    // Reset mid-stream with the queue at its reachable peak of three entries
    bus.lookup_reg = 6'd14;
    step(rq(6'd11, 32'hC1, 1'b0), rq(6'd12, 32'hC2, 1'b0), 1'b1, 1'b1);
    step(rq(6'd13, 32'hC3, 1'b0), rq(6'd14, 32'hC4, 1'b0), 1'b1, 1'b1);
    step(rq(6'd15, 32'hC5, 1'b0), rq(6'd16, 32'hC6, 1'b0), 1'b1, 1'b0);
    @(posedge clk); #1;
    check("mid_hit_before_reset", bus.pending_hit, 1'b1);
    rst_n = 1'b0;
    sb.delete();
    bus.valid_a = 1'b1; bus.reg_a = 6'd20; bus.data_a = 32'hC7; bus.float_a = 1'b0;
    bus.valid_b = 1'b0;
    #1;
    check("mid_rst_ready_a", bus.ready_a, 1'b0);
    check("mid_rst_reg_write", bus.reg_write, 1'b0);
    check("mid_rst_pending_hit", bus.pending_hit, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.valid_a = 1'b0;
    #1;
    check("post_rst_reg_write", bus.reg_write, 1'b0);
    check("post_rst_err_flag", bus.err_flag, 1'b0);
    check("post_rst_pending_hit", bus.pending_hit, 1'b0);
    step(rq(6'd9, 32'h99, 1'b0), NONE, 1'b1, 1'b0);
    idle(4);

    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
